// File: rtl/imem_responder_if.sv
// Fetch/response/load bus between the fetch unit (master) and the
// instruction-memory responder (slave).
interface imem_responder_if #(
    parameter int unsigned N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_inst;
    logic         rsp_err;
    logic         ld_en;
    logic [N-1:0] ld_addr;
    logic [N-1:0] ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: programmable word store with a load port,
// one-cycle fetch latency and a 2-entry response FIFO so fetch can stall
// on backpressure without losing words.
// Optional macro IMEM_ADDR_CHECK_EN: flags misaligned / out-of-range fetches
// (returns NOP_WORD with rsp_err=1) and drops such load writes.
module imem_responder #(
    parameter int unsigned   N        = 32,
    parameter int unsigned   DEPTH    = 256,
    parameter logic [N-1:0]  NOP_WORD = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             init_n,
    imem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TOP   = IDX_W + 2;

    logic [N-1:0]     mem_q [DEPTH];
    logic [N-1:0]     buf_inst_q [2];
    logic             buf_err_q [2];
    logic             rd_ptr_q;
    logic             rd_ptr_d;
    logic             wr_ptr_q;
    logic             wr_ptr_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic [IDX_W-1:0] req_idx_s;
    logic [IDX_W-1:0] ld_idx_s;
    logic             req_err_s;
    logic             ld_we_s;
    logic             req_ready_s;
    logic             rsp_valid_s;
    logic             push_s;
    logic             pop_s;
    logic [N-1:0]     push_inst_s;

    // Address bits that only matter when range/alignment checking is built in.
    logic             unused_addr_s;
    assign unused_addr_s = ^{bus.req_addr, bus.ld_addr};

    // Address decode, handshake qualification and FIFO next-state.
    always_comb begin
        req_idx_s = bus.req_addr[TOP-1:2];
        ld_idx_s  = bus.ld_addr[TOP-1:2];
`ifdef IMEM_ADDR_CHECK_EN
        req_err_s = (bus.req_addr[1:0] != 2'b00) ||
                    ((bus.req_addr >> TOP) != {N{1'b0}});
        ld_we_s   = bus.ld_en && (bus.ld_addr[1:0] == 2'b00) &&
                    ((bus.ld_addr >> TOP) == {N{1'b0}});
`else
        req_err_s = 1'b0;
        ld_we_s   = bus.ld_en;
`endif
        // Load owns the cycle; FIFO fullness is the only other gate, so
        // req_ready never depends on rsp_ready or req_valid.
        req_ready_s = !bus.ld_en && (count_q != 2'd2);
        rsp_valid_s = (count_q != 2'd0);
        push_s      = bus.req_valid && req_ready_s;
        pop_s       = rsp_valid_s && bus.rsp_ready;

        if (req_err_s) begin
            push_inst_s = NOP_WORD;
        end else begin
            push_inst_s = mem_q[req_idx_s];
        end

        if (push_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Program store: written only by the load port, never reset.
    always_ff @(posedge clk) begin
        if (ld_we_s) begin
            mem_q[ld_idx_s] <= bus.ld_data;
        end
    end

    // Response FIFO state; a reset discards every buffered response.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            buf_inst_q[0] <= {N{1'b0}};
            buf_inst_q[1] <= {N{1'b0}};
            buf_err_q[0]  <= 1'b0;
            buf_err_q[1]  <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push_s) begin
                buf_inst_q[wr_ptr_q] <= push_inst_s;
                buf_err_q[wr_ptr_q]  <= req_err_s;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_inst  = buf_inst_q[rd_ptr_q];
`ifdef IMEM_ADDR_CHECK_EN
    assign bus.rsp_err   = buf_err_q[rd_ptr_q];
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder plus hand-written
// sequences for asynchronous reset during operation.
module tb_imem_responder;
    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h00A0_0113;
    localparam logic [31:0] W2  = 32'h0030_0193;
    localparam logic [31:0] W3  = 32'h0040_0213;
    localparam logic [31:0] WN  = 32'hDEAD_BEEF;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] OOR = DEPTH * 4;
`ifdef IMEM_ADDR_CHECK_EN
    localparam logic [31:0] E_INST = NOP;
    localparam logic        E_ERR  = 1'b1;
`else
    localparam logic [31:0] E_INST = W0;
    localparam logic        E_ERR  = 1'b0;
`endif

    logic clk = 1'b0;
    logic init_n;
    int   total = 0;
    int   bad   = 0;

    imem_responder_if #(.N(N)) bus ();

    imem_responder #(.N(N), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld_en;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        e_rdy;
        logic        e_vld;
        logic        chk_inst;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld_en, input logic [31:0] ld_addr, input logic [31:0] ld_data,
                       input logic rv, input logic [31:0] ra, input logic rr,
                       input logic e_rdy, input logic e_vld, input logic chk_inst,
                       input logic [31:0] e_inst, input logic e_err);
        vec_t v;
        v.ld_en = ld_en; v.ld_addr = ld_addr; v.ld_data = ld_data;
        v.rv = rv; v.ra = ra; v.rr = rr;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk_inst = chk_inst;
        v.e_inst = e_inst; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld_en, input logic [31:0] ld_addr, input logic [31:0] ld_data,
                         input logic rv, input logic [31:0] ra, input logic rr);
        bus.ld_en     = ld_en;
        bus.ld_addr   = ld_addr;
        bus.ld_data   = ld_data;
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rr;
    endtask

    initial begin
        //   ld  ld_addr  ld_data  rv  ra     rr    rdy  vld  chk  inst    err
        // loads, with a competing fetch on the first one
        add(1'b1, 32'h0, W0,   1'b1, 32'h0, 1'b1,  1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        add(1'b1, 32'h4, W1,   1'b0, 32'h0, 1'b1,  1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        add(1'b1, 32'h8, W2,   1'b0, 32'h0, 1'b1,  1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        add(1'b1, 32'hC, W3,   1'b0, 32'h0, 1'b1,  1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        // back-to-back fetch 0x0, 0x4
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1, W0,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, W1,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // backpressure: two accepted, third stalls until a pop
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b1, W0,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1, W0,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b1, W0,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 1'b1, W1,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, W2,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // simultaneous push/pop with one entry resident
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b1, W0,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 1'b1, W3,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1, W2,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, W1,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, W0,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // read-after-load: buffered word keeps old value, later fetch sees new
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        add(1'b1, 32'h4, WN,    1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, W1,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b1, W1,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, W1,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, WN,    1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // out-of-range and misaligned fetches
        add(1'b0, 32'h0, 32'h0, 1'b1, OOR,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b1, E_INST, E_ERR);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, E_INST, E_ERR);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // reset state
        init_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_inst", bus.rsp_inst, 32'h0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        init_n = 1'b1;

        // table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ld_en, vecs[i].ld_addr, vecs[i].ld_data,
                  vecs[i].rv, vecs[i].ra, vecs[i].rr);
            #1;
            check($sformatf("row%0d_req_ready", i), {31'd0, bus.req_ready}, {31'd0, vecs[i].e_rdy});
            check($sformatf("row%0d_rsp_valid", i), {31'd0, bus.rsp_valid}, {31'd0, vecs[i].e_vld});
            if (vecs[i].e_vld) begin
                check($sformatf("row%0d_rsp_err", i), {31'd0, bus.rsp_err}, {31'd0, vecs[i].e_err});
            end
            if (vecs[i].chk_inst) begin
                check($sformatf("row%0d_rsp_inst", i), bus.rsp_inst, vecs[i].e_inst);
            end
        end

        // reset mid-operation with two entries buffered
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("full_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("full_req_ready", {31'd0, bus.req_ready}, 32'd0);
        #1;
        init_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("async_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("async_rst_rsp_inst", bus.rsp_inst, 32'h0);
        @(negedge clk);
        init_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b1);
        #1;
        check("post_rst_rsp_valid0", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        check("post_rst_rsp_valid1", {31'd0, bus.rsp_valid}, 32'd1);
        check("post_rst_rsp_inst", bus.rsp_inst, WN);
        check("post_rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_drained", {31'd0, bus.rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
